// File: rtl/maxnet_pkg.sv
// Shared constants for the four-neuron Maxnet engine: state encoding,
// activation width and the Q0.16 inhibition-weight encoding.
package maxnet_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned N_NEURON = 4;
  localparam int unsigned SEL_W    = 2;

  // epsilon is an unsigned Q0.16 fraction; FRAC_W is the shift after multiply
  localparam int unsigned FRAC_W = 16;
  localparam logic [FRAC_W-1:0] EPS_QUARTER = 16'h4000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/maxnet_neuron_update.sv
// Combinational lateral-inhibition step for one neuron:
// next = max(0, x - floor((sum of peers) * eps / 2^16)).
module maxnet_neuron_update
  import maxnet_pkg::*;
#(
  parameter int unsigned      W   = maxnet_pkg::WIDTH,
  parameter logic [FRAC_W-1:0] EPS = EPS_QUARTER
) (
  input  logic [W-1:0] x_self,
  input  logic [W-1:0] peer_a,
  input  logic [W-1:0] peer_b,
  input  logic [W-1:0] peer_c,
  output logic [W-1:0] x_next_c
);

  localparam int unsigned SUM_W  = W + 2;
  localparam int unsigned PROD_W = SUM_W + FRAC_W;

  logic [SUM_W-1:0]  peer_sum;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  inhib;

  assign peer_sum = SUM_W'(peer_a) + SUM_W'(peer_b) + SUM_W'(peer_c);
  assign prod     = PROD_W'(peer_sum) * PROD_W'(EPS);
  assign inhib    = SUM_W'(prod >> FRAC_W);

  // ReLU clamp: inhibition at or above the current value kills the neuron
  assign x_next_c = (inhib >= SUM_W'(x_self)) ? '0 : (x_self - W'(inhib));

endmodule

// File: rtl/maxnet_core.sv
// Iterative Maxnet winner-take-all engine. Applies one inhibition update per
// clock until the external done checker reports a single survivor or timeout.
module maxnet_core
  import maxnet_pkg::*;
#(
  parameter int unsigned       WIDTH    = maxnet_pkg::WIDTH,
  parameter logic [FRAC_W-1:0] EPS      = EPS_QUARTER,
  parameter int unsigned       MAX_ITER = 255,
  parameter int unsigned       CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             done_in,
  input  logic [1:0]       sel_in,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       winner,
  output logic             no_winner,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q   [N_NEURON];
  logic [WIDTH-1:0] x_d   [N_NEURON];
  logic [WIDTH-1:0] x_upd [N_NEURON];
  logic [WIDTH-1:0] in_v  [N_NEURON];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             busy_d, result_valid_d, no_winner_d, timeout_d;
  logic [1:0]       winner_d;
  logic [CNT_W-1:0] iter_count_d;
  logic             all_zero;

  assign in_v[0] = in0;
  assign in_v[1] = in1;
  assign in_v[2] = in2;
  assign in_v[3] = in3;

  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];

  assign all_zero = (x_q[0] == '0) && (x_q[1] == '0) && (x_q[2] == '0) && (x_q[3] == '0);

  // Neuron i is inhibited by the other three, taken in rotation
  for (genvar i = 0; i < N_NEURON; i++) begin : g_neuron
    maxnet_neuron_update #(
      .W   (WIDTH),
      .EPS (EPS)
    ) u_update (
      .x_self   (x_q[i]),
      .peer_a   (x_q[(i + 1) % N_NEURON]),
      .peer_b   (x_q[(i + 2) % N_NEURON]),
      .peer_c   (x_q[(i + 3) % N_NEURON]),
      .x_next_c (x_upd[i])
    );
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy_d         = busy;
    result_valid_d = 1'b0;
    winner_d       = winner;
    no_winner_d    = no_winner;
    timeout_d      = timeout;
    iter_count_d   = iter_count;
    for (int i = 0; i < N_NEURON; i++) x_d[i] = x_q[i];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < N_NEURON; i++) x_d[i] = in_v[i][WIDTH-1] ? '0 : in_v[i];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (done_in) begin
          winner_d       = sel_in;
          no_winner_d    = all_zero;
          timeout_d      = 1'b0;
          iter_count_d   = cnt_q;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else if (cnt_q == MAX_CNT) begin
          winner_d       = 2'd0;
          no_winner_d    = 1'b0;
          timeout_d      = 1'b1;
          iter_count_d   = cnt_q;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          for (int i = 0; i < N_NEURON; i++) x_d[i] = x_upd[i];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winner       <= 2'd0;
      no_winner    <= 1'b0;
      timeout      <= 1'b0;
      iter_count   <= '0;
      for (int i = 0; i < N_NEURON; i++) x_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy         <= busy_d;
      result_valid <= result_valid_d;
      winner       <= winner_d;
      no_winner    <= no_winner_d;
      timeout      <= timeout_d;
      iter_count   <= iter_count_d;
      for (int i = 0; i < N_NEURON; i++) x_q[i] <= x_d[i];
    end
  end

endmodule

// File: tb/tb_maxnet_core.sv
// Bench for maxnet_core: closes the loop through a combinational done checker
// and compares every run against an arithmetic Maxnet reference model.
module tb_maxnet_core;

  localparam int unsigned W  = 32;
  localparam int unsigned MI = 16;
  localparam int unsigned CW = 8;
  localparam longint      EPS_VAL = 64'h4000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  in0, in1, in2, in3;
  logic          done_in;
  logic [1:0]    sel_in;
  logic [W-1:0]  x0, x1, x2, x3;
  logic          busy, result_valid, no_winner, timeout;
  logic [1:0]    winner;
  logic [CW-1:0] iter_count;
  logic [W-1:0]  xa [4];

  int checks   = 0;
  int failures = 0;

  longint m_traj [MI+1][4];
  int     m_n, m_win;
  bit     m_nowin, m_to;

  int obs_lat, obs_winner, obs_nowin, obs_to, obs_iter;
  longint obs_x [4];

  always #5 clk = ~clk;

  maxnet_core #(
    .WIDTH    (W),
    .EPS      (16'h4000),
    .MAX_ITER (MI),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in0          (in0),
    .in1          (in1),
    .in2          (in2),
    .in3          (in3),
    .done_in      (done_in),
    .sel_in       (sel_in),
    .x0           (x0),
    .x1           (x1),
    .x2           (x2),
    .x3           (x3),
    .busy         (busy),
    .result_valid (result_valid),
    .winner       (winner),
    .no_winner    (no_winner),
    .timeout      (timeout),
    .iter_count   (iter_count)
  );

  assign xa[0] = x0;
  assign xa[1] = x1;
  assign xa[2] = x2;
  assign xa[3] = x3;

  // Downstream done checker: done when at most one activation is nonzero
  int nz_cnt;
  always_comb begin
    nz_cnt = 0;
    sel_in = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (xa[i] != '0) begin
        nz_cnt = nz_cnt + 1;
        sel_in = 2'(i);
      end
    end
    done_in = (nz_cnt <= 1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_run(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    longint xv [4];
    longint nx [4];
    longint tot, p;
    int nz, idx;
    xv[0] = a[W-1] ? 0 : longint'({32'b0, a});
    xv[1] = b[W-1] ? 0 : longint'({32'b0, b});
    xv[2] = c[W-1] ? 0 : longint'({32'b0, c});
    xv[3] = d[W-1] ? 0 : longint'({32'b0, d});
    m_n = 0;
    for (int i = 0; i < 4; i++) m_traj[0][i] = xv[i];
    for (int it = 0; it <= int'(MI) + 1; it++) begin
      nz = 0;
      idx = 0;
      for (int i = 0; i < 4; i++) if (xv[i] != 0) begin nz++; idx = i; end
      if (nz <= 1) begin
        m_win = (nz == 1) ? idx : 0;
        m_nowin = (nz == 0);
        m_to = 1'b0;
        break;
      end
      if (m_n == int'(MI)) begin
        m_win = 0;
        m_nowin = 1'b0;
        m_to = 1'b1;
        break;
      end
      tot = xv[0] + xv[1] + xv[2] + xv[3];
      for (int i = 0; i < 4; i++) begin
        p = ((tot - xv[i]) * EPS_VAL) / 65536;
        nx[i] = (p >= xv[i]) ? 0 : xv[i] - p;
      end
      m_n++;
      for (int i = 0; i < 4; i++) begin
        xv[i] = nx[i];
        m_traj[m_n][i] = nx[i];
      end
    end
  endtask

  // One full run; inject>0 pulses start with junk inputs before that edge,
  // inject_done pulses it during the DONE cycle.
  task automatic run_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d,
                          input int inject, input bit inject_done);
    bit found;
    int k;
    model_run(a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, "_busy_load"}, 64'(busy), 64'd1);
    check_val({tag, "_rv_load"}, 64'(result_valid), 64'd0);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s_load_x%0d", tag, i), 64'(xa[i]), 64'(m_traj[0][i]));
    found = 1'b0;
    obs_lat = -1;
    for (int j = 1; j <= int'(MI) + 4 && !found; j++) begin
      if (j == inject) begin
        in0 = 32'd100; in1 = 32'd200; in2 = 32'd300; in3 = 32'd400;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      k = (j < m_n) ? j : m_n;
      for (int i = 0; i < 4; i++)
        check_val($sformatf("%s_c%0d_x%0d", tag, j, i), 64'(xa[i]), 64'(m_traj[k][i]));
      if (result_valid) begin
        found = 1'b1;
        obs_lat = j + 1;
        obs_winner = int'(winner);
        obs_nowin = int'(no_winner);
        obs_to = int'(timeout);
        obs_iter = int'(iter_count);
        for (int i = 0; i < 4; i++) obs_x[i] = longint'({32'b0, xa[i]});
      end else begin
        check_val($sformatf("%s_c%0d_busy", tag, j), 64'(busy), 64'd1);
      end
    end
    check_val({tag, "_found"}, 64'(found), 64'd1);
    check_val({tag, "_latency"}, 64'(obs_lat), 64'(m_n + 2));
    check_val({tag, "_winner"}, 64'(obs_winner), 64'(m_win));
    check_val({tag, "_no_winner"}, 64'(obs_nowin), 64'(m_nowin));
    check_val({tag, "_timeout"}, 64'(obs_to), 64'(m_to));
    check_val({tag, "_iter"}, 64'(obs_iter), 64'(m_n));
    if (inject_done) begin
      in0 = 32'd100; in1 = 32'd200; in2 = 32'd300; in3 = 32'd400;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, "_rv_pulse"}, 64'(result_valid), 64'd0);
    check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_val({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check_val({tag, "_hold_winner"}, 64'(winner), 64'(m_win));
    check_val({tag, "_hold_iter"}, 64'(iter_count), 64'(m_n));
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s_hold_x%0d", tag, i), 64'(xa[i]), 64'(m_traj[m_n][i]));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_rv"}, 64'(result_valid), 64'd0);
    check_val({tag, "_winner"}, 64'(winner), 64'd0);
    check_val({tag, "_no_winner"}, 64'(no_winner), 64'd0);
    check_val({tag, "_timeout"}, 64'(timeout), 64'd0);
    check_val({tag, "_iter"}, 64'(iter_count), 64'd0);
    for (int i = 0; i < 4; i++) check_val($sformatf("%s_x%0d", tag, i), 64'(xa[i]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r [4];
    int mode;
    rst_n = 1'b0;
    start = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_case("conv", 32'd10, 32'd8, 32'd6, 32'd4, 0, 1'b0);
    check_val("conv_winner_c", 64'(obs_winner), 64'd0);
    check_val("conv_iter_c", 64'(obs_iter), 64'd4);
    check_val("conv_x0_c", 64'(obs_x[0]), 64'd5);
    check_val("conv_lat_c", 64'(obs_lat), 64'd6);

    run_case("imm", 32'd0, 32'd0, 32'd7, 32'd0, 0, 1'b0);
    check_val("imm_winner_c", 64'(obs_winner), 64'd2);
    check_val("imm_lat_c", 64'(obs_lat), 64'd2);

    run_case("tie", 32'd5, 32'd5, 32'd0, 32'd0, 0, 1'b0);
    check_val("tie_timeout_c", 64'(obs_to), 64'd1);
    check_val("tie_winner_c", 64'(obs_winner), 64'd0);
    check_val("tie_iter_c", 64'(obs_iter), 64'd16);
    check_val("tie_lat_c", 64'(obs_lat), 64'd18);
    check_val("tie_x0_c", 64'(obs_x[0]), 64'd3);

    run_case("neg", 32'hFFFF_FFFD, 32'd2, 32'd0, 32'd0, 0, 1'b0);
    check_val("neg_winner_c", 64'(obs_winner), 64'd1);
    check_val("neg_iter_c", 64'(obs_iter), 64'd0);
    check_val("neg_x0_c", 64'(obs_x[0]), 64'd0);

    // Asynchronous reset in the middle of a convergence run
    in0 = 32'd10; in1 = 32'd8; in2 = 32'd6; in3 = 32'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_idle_busy", 64'(busy), 64'd0);

    run_case("allzero", 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    check_val("allzero_nowin_c", 64'(obs_nowin), 64'd1);
    check_val("allzero_winner_c", 64'(obs_winner), 64'd0);

    run_case("ign", 32'd10, 32'd8, 32'd6, 32'd4, 2, 1'b1);
    check_val("ign_winner_c", 64'(obs_winner), 64'd0);
    check_val("ign_iter_c", 64'(obs_iter), 64'd4);
    check_val("ign_x0_c", 64'(obs_x[0]), 64'd5);

    for (int n = 0; n < 24; n++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        case (mode)
          0: r[i] = 32'($urandom_range(0, 20));
          1: r[i] = 32'($urandom_range(0, 1000));
          2: r[i] = 32'($urandom);
          default: r[i] = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
        endcase
      end
      run_case($sformatf("rnd%0d", n), r[0], r[1], r[2], r[3], 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
